// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if
//   Register bus between spi_flash_reader (master) and spi_master (slave).
//   o_spi_en    1-cycle access strobe
//   o_spi_wr    1 = write, 0 = read
//   o_spi_addr  0 STATUS, 1 DATA_OUT, 2 DATA_IN, 3 CTRL
//   o_spi_data  write data
//   i_spi_data  read data, valid the cycle after a read strobe
interface spi_flash_reader_if;
  logic       o_spi_en;
  logic       o_spi_wr;
  logic [3:0] o_spi_addr;
  logic [7:0] o_spi_data;
  logic [7:0] i_spi_data;

  modport master (output o_spi_en, o_spi_wr, o_spi_addr, o_spi_data,
                  input  i_spi_data);
  modport slave  (input  o_spi_en, o_spi_wr, o_spi_addr, o_spi_data,
                  output i_spi_data);
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   Runs a SPI-flash READ (0x03) through spi_master's register bus: selects
//   the device, sends opcode + 24-bit address, clocks in i_len bytes with
//   dummy writes and streams them out on a valid/ready port.
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start, i_faddr,     request (sampled in IDLE only)
//   i_len
//   o_busy, o_done, o_err status; o_err qualifies o_done (poll timeout)
//   o_rd_data, o_rd_valid, i_rd_ready  received byte stream
//   bus                   register bus to spi_master (master modport)
module spi_flash_reader #(
  parameter int         LEN_W    = 16,
  parameter logic [4:0] CLK_DIV  = 5'd3,
  parameter logic [1:0] SPI_MODE = 2'd0,
  parameter int         POLL_MAX = 1023
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [23:0]      i_faddr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  spi_flash_reader_if.master bus
);

  localparam int PW = $clog2(POLL_MAX + 1);

  localparam logic [3:0] A_STATUS = 4'd0;
  localparam logic [3:0] A_DOUT   = 4'd1;
  localparam logic [3:0] A_DIN    = 4'd2;
  localparam logic [3:0] A_CTRL   = 4'd3;

  localparam logic [7:0] CTRL_SEL   = {CLK_DIV, 1'b1, SPI_MODE};
  localparam logic [7:0] CTRL_DESEL = {CLK_DIV, 1'b0, SPI_MODE};

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_TX_WR, S_TX_GAP, S_POLL_RD, S_POLL_CHK,
    S_RX_RD, S_RX_CHK, S_OUT, S_DESEL, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [23:0]      r_addr;
  logic [LEN_W-1:0] r_rem;
  logic [2:0]       r_idx;    // 0..3 header byte, 4 = data phase (dummy writes)
  logic [PW-1:0]    r_poll;   // STATUS reads already done for this byte, minus the current one
  logic [7:0]       r_data;
  logic             r_err;

  logic       w_en, w_wr;
  logic [3:0] w_addr;
  logic [7:0] w_wdata, w_tx;
  logic       w_spi_busy, w_timeout;

  assign w_spi_busy = bus.i_spi_data[0];
  assign w_timeout  = (r_poll == PW'(POLL_MAX - 1));

  always_comb begin
    case (r_idx)
      3'd0:    w_tx = 8'h03;
      3'd1:    w_tx = r_addr[23:16];
      3'd2:    w_tx = r_addr[15:8];
      3'd3:    w_tx = r_addr[7:0];
      default: w_tx = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_en    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = 4'd0;
    w_wdata = 8'd0;
    case (r_state)
      S_IDLE:
        if (i_start) w_next = (i_len == '0) ? S_DONE : S_SEL;
      S_SEL: begin
        w_en = 1'b1; w_wr = 1'b1; w_addr = A_CTRL; w_wdata = CTRL_SEL;
        w_next = S_TX_WR;
      end
      S_TX_WR: begin
        w_en = 1'b1; w_wr = 1'b1; w_addr = A_DOUT; w_wdata = w_tx;
        w_next = S_TX_GAP;
      end
      // one idle cycle so spi_master's busy flag is up before the first poll
      S_TX_GAP: w_next = S_POLL_RD;
      S_POLL_RD: begin
        w_en = 1'b1; w_addr = A_STATUS;
        w_next = S_POLL_CHK;
      end
      S_POLL_CHK:
        if (w_spi_busy)    w_next = w_timeout ? S_DESEL : S_POLL_RD;
        else if (r_idx[2]) w_next = S_RX_RD;
        else               w_next = S_TX_WR;
      S_RX_RD: begin
        w_en = 1'b1; w_addr = A_DIN;
        w_next = S_RX_CHK;
      end
      S_RX_CHK: w_next = S_OUT;
      S_OUT:
        if (i_rd_ready) w_next = (r_rem <= LEN_W'(1)) ? S_DESEL : S_TX_WR;
      S_DESEL: begin
        w_en = 1'b1; w_wr = 1'b1; w_addr = A_CTRL; w_wdata = CTRL_DESEL;
        w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_idx  <= '0;
      r_poll <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (i_start) begin
            r_addr <= i_faddr;
            r_rem  <= i_len;
            r_idx  <= '0;
            r_err  <= 1'b0;
          end
        S_TX_WR: r_poll <= '0;
        S_POLL_CHK:
          if (w_spi_busy) begin
            if (w_timeout) r_err  <= 1'b1;
            else           r_poll <= r_poll + 1'b1;
          end else if (!r_idx[2]) begin
            r_idx <= r_idx + 1'b1;   // header byte done; 3 -> 4 enters data phase
          end
        S_RX_CHK: r_data <= bus.i_spi_data;
        S_OUT:
          if (i_rd_ready && r_rem != '0) r_rem <= r_rem - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.o_spi_en   = w_en;
  assign bus.o_spi_wr   = w_wr;
  assign bus.o_spi_addr = w_addr;
  assign bus.o_spi_data = w_wdata;

  assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = r_err;
  assign o_rd_valid = (r_state == S_OUT);
  assign o_rd_data  = r_data;

endmodule
